// File: rtl/cam_capture_scaler.sv
// cam_capture_scaler: OV7670 RGB565 byte-stream capture front end.
// Pairs camera bytes into pixels, decimates by DEC in both axes, repacks to
// RGB444 or RGB332 and emits row-major frame-buffer writes. Also provides
// continuous/single-shot capture control, a frame counter and sticky error
// flags for malformed lines and frames with too many lines.
module cam_capture_scaler #(
  parameter int AW   = 15,
  parameter int DW   = 12,
  parameter int IN_W = 160,
  parameter int IN_H = 120,
  parameter int DEC  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic          single_shot,
  input  logic          fmt_sel,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          err_line,
  output logic          err_ovf
);

  localparam int OUT_W = IN_W / DEC;
  localparam int OUT_H = IN_H / DEC;
  localparam int DCW   = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int CW    = $clog2(OUT_W + 1);
  localparam int RW    = $clog2(OUT_H + 1);
  localparam int BW    = $clog2(2 * IN_W) + 1;
  localparam logic [BW-1:0] LINE_BYTES = BW'(2 * IN_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOF, S_ACTIVE, S_DONE, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_d;
  logic            line_open_q, line_open_d;   // at least one byte taken on current line
  logic            phase_q, phase_d;           // 0: expecting b0, 1: expecting b1
  logic [6:0]      b0_q, b0_d;                 // {b0[7:4], b0[2:0]}; b0[3] never used
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;     // saturating bytes-on-line count
  logic [DCW-1:0]  dcol_q, dcol_d;             // input column mod DEC
  logic [DCW-1:0]  drow_q, drow_d;             // input row mod DEC
  logic [CW-1:0]   col_out_q, col_out_d;       // kept column index, saturates at OUT_W
  logic [RW-1:0]   row_out_q, row_out_d;       // kept line index, saturates at OUT_H
  logic [AW-1:0]   row_base_q, row_base_d;
  logic            regw_q, regw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            err_line_q, err_line_d;
  logic            err_ovf_q, err_ovf_d;

  logic sof, eof, accept, line_end, keep_px;

  assign sof      = vsync_q & ~CAM_vsync;
  assign eof      = ~vsync_q & CAM_vsync;
  // A byte arriving on the EOF cycle is not taken; that cycle closes the line.
  assign accept   = (state_q == S_ACTIVE) & CAM_href & ~eof;
  assign line_end = (state_q == S_ACTIVE) & line_open_q & (~CAM_href | eof);
  assign keep_px  = (dcol_q == '0) && (drow_q == '0) &&
                    (col_out_q < CW'(OUT_W)) && (row_out_q < RW'(OUT_H));

  // Next-state, capture datapath and write generation.
  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves a
    // variable unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    vsync_d     = CAM_vsync;
    line_open_d = line_open_q;
    phase_d     = phase_q;
    b0_d        = b0_q;
    byte_cnt_d  = byte_cnt_q;
    dcol_d      = dcol_q;
    drow_d      = drow_q;
    col_out_d   = col_out_q;
    row_out_d   = row_out_q;
    row_base_d  = row_base_q;
    regw_d      = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    err_line_d  = err_line_q;
    err_ovf_d   = err_ovf_q;

    unique case (state_q)
      S_IDLE:     if (cap_en) state_d = S_WAIT_SOF;
      S_WAIT_SOF: if (sof) begin
        state_d     = S_ACTIVE;
        line_open_d = 1'b0;
        phase_d     = 1'b0;
        byte_cnt_d  = '0;
        dcol_d      = '0;
        drow_d      = '0;
        col_out_d   = '0;
        row_out_d   = '0;
        row_base_d  = '0;
        err_line_d  = 1'b0;
        err_ovf_d   = 1'b0;
      end
      S_ACTIVE:   if (eof) state_d = S_DONE;
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (single_shot)  state_d = S_HALT;
        else if (!cap_en) state_d = S_IDLE;
        else              state_d = S_WAIT_SOF;
      end
      S_HALT:     if (!cap_en) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (accept) begin
      line_open_d = 1'b1;
      phase_d     = ~phase_q;
      if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BW'(1);
      if (!phase_q) begin
        b0_d = {CAM_px_data[7:4], CAM_px_data[2:0]};
      end else begin
        if (keep_px) begin
          regw_d = 1'b1;
          addr_d = row_base_q + AW'(col_out_q);
          if (fmt_sel) data_d = DW'({b0_q[6:4], b0_q[2:0], CAM_px_data[4:3]});
          else         data_d = DW'({b0_q[6:3], b0_q[2:0], CAM_px_data[7], CAM_px_data[4:1]});
        end
        if (dcol_q == '0 && col_out_q < CW'(OUT_W)) col_out_d = col_out_q + CW'(1);
        dcol_d = (dcol_q == DCW'(DEC - 1)) ? '0 : dcol_q + DCW'(1);
      end
    end

    if (line_end) begin
      line_open_d = 1'b0;
      if (phase_q || byte_cnt_q != LINE_BYTES) err_line_d = 1'b1;
      phase_d    = 1'b0;
      byte_cnt_d = '0;
      dcol_d     = '0;
      col_out_d  = '0;
      // Row base advances by a full output line, so short lines never skew rows.
      if (drow_q == '0) begin
        if (row_out_q < RW'(OUT_H)) begin
          row_out_d  = row_out_q + RW'(1);
          row_base_d = row_base_q + AW'(OUT_W);
        end else begin
          err_ovf_d = 1'b1;
        end
      end
      drow_d = (drow_q == DCW'(DEC - 1)) ? '0 : drow_q + DCW'(1);
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      line_open_q <= 1'b0;
      phase_q     <= 1'b0;
      b0_q        <= '0;
      byte_cnt_q  <= '0;
      dcol_q      <= '0;
      drow_q      <= '0;
      col_out_q   <= '0;
      row_out_q   <= '0;
      row_base_q  <= '0;
      regw_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      err_line_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      line_open_q <= line_open_d;
      phase_q     <= phase_d;
      b0_q        <= b0_d;
      byte_cnt_q  <= byte_cnt_d;
      dcol_q      <= dcol_d;
      drow_q      <= drow_d;
      col_out_q   <= col_out_d;
      row_out_q   <= row_out_d;
      row_base_q  <= row_base_d;
      regw_q      <= regw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      err_line_q  <= err_line_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign DP_RAM_regW    = regw_q;
  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign busy           = (state_q == S_WAIT_SOF) || (state_q == S_ACTIVE);
  assign frame_done     = (state_q == S_DONE);
  assign frame_cnt      = frame_cnt_q;
  assign err_line       = err_line_q;
  assign err_ovf        = err_ovf_q;

endmodule
